// File: rtl/logic_lab_pkg.sv
// Shared definitions for the switch conditioner: debounce FSM state encoding
// and the default qualification length.
package logic_lab_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

  // Gray-ordered so the debounced level is always state[1].
  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'b00,
    ST_PEND_HI   = 2'b01,
    ST_STABLE_HI = 2'b11,
    ST_PEND_LO   = 2'b10
  } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, qualify counter, 4-state debounce
// FSM and registered level output. Edge strobes exist only when
// SWDB_EDGE_PULSE_EN is defined.
module debounce_channel
  import logic_lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 2
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iSw,
  output logic oLvl
`ifdef SWDB_EDGE_PULSE_EN
  ,
  output logic oRise,
  output logic oFall
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q;

  // Two-flop synchronizer; only s2 is trusted downstream.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= iSw;
      s2_q <= s1_q;
    end
  end

  // FSM state and qualify-count registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_STABLE_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a new level must hold DEBOUNCE_CYCLES samples; one sample of
  // the old level aborts and clears the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_STABLE_LO: if (s2_q) begin
        state_d = ST_PEND_HI;
        cnt_d   = CNT_ONE;
      end
      ST_PEND_HI: begin
        if (!s2_q) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE_HI: if (!s2_q) begin
        state_d = ST_PEND_LO;
        cnt_d   = CNT_ONE;
      end
      ST_PEND_LO: begin
        if (s2_q) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered level output, a pure function of state.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) lvl_q <= 1'b0;
    else         lvl_q <= state_q[1];
  end

  assign oLvl = lvl_q;

`ifdef SWDB_EDGE_PULSE_EN
  logic rise_q, fall_q;

  // Strobes coincide with the first cycle the level output shows its new value.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= state_q[1] & ~lvl_q;
      fall_q <= ~state_q[1] & lvl_q;
    end
  end

  assign oRise = rise_q;
  assign oFall = fall_q;
`endif

endmodule

// File: rtl/switch_debounce_2.sv
// Two independent switch debounce channels (A, B) feeding the gate stage.
// Define SWDB_EDGE_PULSE_EN to add the rise/fall strobe ports.
module switch_debounce_2
  import logic_lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iSwA,
  input  logic iSwB,
  output logic oA,
  output logic oB
`ifdef SWDB_EDGE_PULSE_EN
  ,
  output logic oARise,
  output logic oAFall,
  output logic oBRise,
  output logic oBFall
`endif
);

  localparam int NUM_CH = 2;
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [NUM_CH-1:0] sw, lvl;
`ifdef SWDB_EDGE_PULSE_EN
  logic [NUM_CH-1:0] rise, fall;
`endif

  assign sw = {iSwB, iSwA};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .iClk  (iClk),
      .iRst_n(iRst_n),
      .iSw   (sw[g]),
      .oLvl  (lvl[g])
`ifdef SWDB_EDGE_PULSE_EN
      ,
      .oRise (rise[g]),
      .oFall (fall[g])
`endif
    );
  end

  assign oA = lvl[0];
  assign oB = lvl[1];
`ifdef SWDB_EDGE_PULSE_EN
  assign oARise = rise[0];
  assign oAFall = fall[0];
  assign oBRise = rise[1];
  assign oBFall = fall[1];
`endif

endmodule

// File: tb/tb_switch_debounce_2.sv
// Directed bench for switch_debounce_2 at DEBOUNCE_CYCLES=4. Strobe checks
// are compiled in when SWDB_EDGE_PULSE_EN is defined.
module tb_switch_debounce_2;

  logic iClk, iRst_n, iSwA, iSwB;
  logic oA, oB;
  int   n_vec = 0, n_err = 0;
`ifdef SWDB_EDGE_PULSE_EN
  logic oARise, oAFall, oBRise, oBFall;
  int   ra_n = 0, fa_n = 0, rb_n = 0, fb_n = 0, both_n = 0;
`endif

  switch_debounce_2 #(.DEBOUNCE_CYCLES(4)) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iSwA  (iSwA),
    .iSwB  (iSwB),
    .oA    (oA),
    .oB    (oB)
`ifdef SWDB_EDGE_PULSE_EN
    ,
    .oARise(oARise),
    .oAFall(oAFall),
    .oBRise(oBRise),
    .oBFall(oBFall)
`endif
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

`ifdef SWDB_EDGE_PULSE_EN
  // Strobe tallies sampled mid-cycle.
  always @(negedge iClk) begin
    if (oARise) ra_n = ra_n + 1;
    if (oAFall) fa_n = fa_n + 1;
    if (oBRise) rb_n = rb_n + 1;
    if (oBFall) fb_n = fb_n + 1;
    if ((oARise && oAFall) || (oBRise && oBFall)) both_n = both_n + 1;
  end
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1ns past the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

`ifdef SWDB_EDGE_PULSE_EN
  int ra0, rb0, fa0, fb0;
`endif

  initial begin
    iRst_n = 1'b0; iSwA = 1'b1; iSwB = 1'b1;
    tick(3);
    // Reset held with switches high.
    chk("rst_oA", int'(oA), 0);
    chk("rst_oB", int'(oB), 0);
`ifdef SWDB_EDGE_PULSE_EN
    chk("rst_strobes", int'({oARise, oAFall, oBRise, oBFall}), 0);
`endif
    iRst_n = 1'b1;
    tick(6);
    chk("rel_oA_c6", int'(oA), 0);
    tick(1);
    chk("rel_oA_c7", int'(oA), 1);
    chk("rel_oB_c7", int'(oB), 1);
`ifdef SWDB_EDGE_PULSE_EN
    chk("rel_ARise", int'(oARise), 1);
    chk("rel_BRise", int'(oBRise), 1);
`endif
    tick(1);
`ifdef SWDB_EDGE_PULSE_EN
    chk("rel_ARise_off", int'(oARise), 0);
`endif
    // Both fall.
    iSwA = 1'b0; iSwB = 1'b0;
    tick(6);
    chk("fall_oA_c6", int'(oA), 1);
    tick(1);
    chk("fall_oA_c7", int'(oA), 0);
    chk("fall_oB_c7", int'(oB), 0);
`ifdef SWDB_EDGE_PULSE_EN
    chk("fall_AFall", int'(oAFall), 1);
`endif
    tick(3);

    // Clean step on A.
    iSwA = 1'b1;
    tick(6);
    chk("step_oA_c6", int'(oA), 0);
    tick(1);
    chk("step_oA_c7", int'(oA), 1);
    chk("step_oB", int'(oB), 0);
`ifdef SWDB_EDGE_PULSE_EN
    chk("step_ARise", int'(oARise), 1);
    chk("step_AFall", int'(oAFall), 0);
`endif
    tick(1);
`ifdef SWDB_EDGE_PULSE_EN
    chk("step_ARise_off", int'(oARise), 0);
`endif
    iSwA = 1'b0;
    tick(8);
    chk("step_back_oA", int'(oA), 0);

    // Bounce 1,0,1,0 then held 1.
`ifdef SWDB_EDGE_PULSE_EN
    ra0 = ra_n;
`endif
    iSwA = 1'b1; tick(1);
    iSwA = 1'b0; tick(1);
    iSwA = 1'b1; tick(1);
    iSwA = 1'b0; tick(1);
    iSwA = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("bounce_hold_oA", int'(oA), 0);
    end
    tick(1);
    chk("bounce_oA_c7", int'(oA), 1);
    tick(2);
`ifdef SWDB_EDGE_PULSE_EN
    chk("bounce_rise_cnt", ra_n - ra0, 1);
`endif
    iSwA = 1'b0;
    tick(8);
    chk("bounce_back_oA", int'(oA), 0);

    // 3-cycle glitch on B.
`ifdef SWDB_EDGE_PULSE_EN
    rb0 = rb_n;
`endif
    iSwB = 1'b1; tick(3);
    iSwB = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch_oB", int'(oB), 0);
    end
`ifdef SWDB_EDGE_PULSE_EN
    chk("glitch_rise_cnt", rb_n - rb0, 0);
`endif

    // Simultaneous rise.
    iSwA = 1'b1; iSwB = 1'b1;
    tick(6);
    chk("sim_oA_c6", int'(oA), 0);
    chk("sim_oB_c6", int'(oB), 0);
    tick(1);
    chk("sim_oA_c7", int'(oA), 1);
    chk("sim_oB_c7", int'(oB), 1);
    tick(2);
`ifdef SWDB_EDGE_PULSE_EN
    fa0 = fa_n; fb0 = fb_n;
`endif
    // Drop both; after 4 edges both channels sit in PEND_LO.
    iSwA = 1'b0; iSwB = 1'b0;
    tick(4);
    chk("pend_oA", int'(oA), 1);
    chk("pend_oB", int'(oB), 1);
    iRst_n = 1'b0;
    #1;
    chk("async_rst_oA", int'(oA), 0);
    chk("async_rst_oB", int'(oB), 0);
    tick(2);
    iRst_n = 1'b1;
    tick(10);
    chk("post_rst_oA", int'(oA), 0);
    chk("post_rst_oB", int'(oB), 0);
`ifdef SWDB_EDGE_PULSE_EN
    chk("post_rst_AFall_cnt", fa_n - fa0, 0);
    chk("post_rst_BFall_cnt", fb_n - fb0, 0);
    chk("rise_fall_overlap", both_n, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
